psum_tx: RTL and testbench
==========================

Name: psum_tx

Overview:
- PE-side transmitter for partial sums travelling to the accumulating adder node.
- Each accepted partial sum is saturated, tagged with a sequential output index, and packed with source and destination node addresses.
- Packets are buffered in a small FIFO and sent into the router over a valid/ready link.
- Tracks the per-layer output count and signals layer completion to the control center through a done/ack handshake.

Parameters:
- ADDR_W, 4, node address width (src and dst fields)
- IDX_W, 7, output-index field width
- ACC_W, 24, width of incoming signed MAC accumulator value
- PSUM_W, 13, signed partial-sum field width in packet
- PKT_W, IDX_W+2*ADDR_W+PSUM_W (=28), packet width
- FIFO_DEPTH, 4, packet buffer entries (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cfg_valid  in  1  load layer config (accepted only in IDLE)
- cfg_tot_num  in  IDX_W  outputs in this layer (1..2^IDX_W-1; 0 is ignored)
- cfg_src  in  ADDR_W  this PE's node address
- cfg_dst  in  ADDR_W  adder node address
- psum_valid  in  1  partial sum offered
- psum_data  in  ACC_W  signed partial sum
- psum_ready  out  1  partial sum accepted when valid&ready
- pkt_valid  out  1  packet offered to router
- pkt_data  out  PKT_W  {idx, src, dst, psum}, MSB first
- pkt_ready  in  1  router accepts
- done_valid  out  1  layer complete, to control center
- done_ack  in  1  control center acknowledge

Behaviour:
- Reset (async, rst=1):
  - All outputs 0; FIFO empty.
  - idx, sent_cnt and config registers are 0.
  - State IDLE.
  - A reset mid-layer discards all buffered packets.
- States:
  - IDLE: psum_ready=0. cfg_valid=1 with cfg_tot_num≠0 latches config, clears idx and sent_cnt, and moves to RUN next cycle.
  - RUN: psum_ready = !fifo_full && (idx < tot_num). When idx reaches tot_num, move to DRAIN.
  - DRAIN: psum_ready=0. When sent_cnt == tot_num and the FIFO is empty, move to DONE.
  - DONE: done_valid=1 and held. On done_ack=1, done_valid=0 and return to IDLE next cycle. done_ack outside DONE is ignored.
- Accept (psum_valid & psum_ready):
  - Push {idx, src, dst, sat(psum_data)} into the FIFO.
  - idx increments by 1.
  - Latency from accept to pkt_valid is 1 cycle when the FIFO was empty.
- Saturation:
  - sat clamps the signed ACC_W value to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1] = [-4096, 4095].
  - In-range values pass through unchanged, two's complement.
- Output link:
  - pkt_valid = !fifo_empty; pkt_data = FIFO head.
  - Once pkt_valid is asserted, pkt_data stays stable until pkt_ready.
  - Pop on pkt_valid & pkt_ready; sent_cnt increments.
- FIFO boundaries:
  - Push and pop in the same cycle when full: allowed. Because psum_ready uses the registered full flag, the push is blocked that cycle; throughput is not required at full.
  - Push and pop in the same cycle when empty: no bypass; the pushed entry appears the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Indices: idx is never reused within a layer and no wrap occurs within a layer; idx resets to 0 on each new cfg.
- cfg_valid in RUN, DRAIN or DONE is ignored; config registers are unchanged.

Decomposition:
- Shared package psum_pkg:
  - Parameter defaults and field offsets (IDX_LSB, SRC_LSB, DST_LSB).
  - Packet struct typedef.
  - Function pack_psum(idx, src, dst, psum).
  - Function sat_psum(acc).
  - State enum {IDLE, RUN, DRAIN, DONE}.
- Sub-module psum_fifo: synchronous FIFO with async reset, full/empty flags and parameterised width/depth.

Test Plan:
- Reset then cfg(tot_num=3, src=2, dst=9), psums 10, -5, 100 with pkt_ready=1 -> packets idx 0/1/2, src=2, dst=9, psum 10, 0x1FFB, 100; done_valid rises after the third pop; done_ack returns to IDLE.
- Saturation: psum_data = 5000 -> field 4095; -70000 -> -4096 (0x1000); 4095 -> unchanged.
- Backpressure: pkt_ready=0, 6 psums offered -> exactly 4 accepted, then psum_ready=0 and pkt_data stable. Release pkt_ready -> remaining 2 accepted, in-order idx 0..5 delivered.
- Ordering: tot_num=2, a 3rd psum offered -> psum_ready stays 0, no extra packet. cfg_valid during RUN -> ignored.
- Reset mid-layer: after 2 of 5 packets are buffered, pulse rst -> pkt_valid=0 immediately. New cfg(tot_num=1) -> a single packet with idx=0.
- done_ack held high before DONE -> no effect. done_valid stays asserted until ack; a new cfg while DONE is ignored.

Source files
------------

// File: rtl/psum_pkg.sv
// Shared types and helpers for the partial-sum transmitter: packet layout,
// saturation and the layer FSM states.
package psum_pkg;

  localparam int ADDR_W     = 4;
  localparam int IDX_W      = 7;
  localparam int ACC_W      = 24;
  localparam int PSUM_W     = 13;
  localparam int PKT_W      = IDX_W + 2*ADDR_W + PSUM_W;
  localparam int FIFO_DEPTH = 4;

  localparam int PSUM_LSB = 0;
  localparam int DST_LSB  = PSUM_LSB + PSUM_W;
  localparam int SRC_LSB  = DST_LSB + ADDR_W;
  localparam int IDX_LSB  = SRC_LSB + ADDR_W;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [PSUM_W-1:0] psum;
  } pkt_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  function automatic logic [PKT_W-1:0] pack_psum(
    input logic [IDX_W-1:0]  idx,
    input logic [ADDR_W-1:0] src,
    input logic [ADDR_W-1:0] dst,
    input logic [PSUM_W-1:0] psum
  );
    logic [PKT_W-1:0] p;
    p = '0;
    p[IDX_LSB  +: IDX_W]  = idx;
    p[SRC_LSB  +: ADDR_W] = src;
    p[DST_LSB  +: ADDR_W] = dst;
    p[PSUM_LSB +: PSUM_W] = psum;
    return p;
  endfunction

  // In range exactly when every bit above the psum sign bit matches it.
  function automatic logic [PSUM_W-1:0] sat_psum(input logic [ACC_W-1:0] acc);
    logic [ACC_W-PSUM_W:0] top;
    top = acc[ACC_W-1:PSUM_W-1];
    if ((&top) || !(|top))
      return acc[PSUM_W-1:0];
    else if (acc[ACC_W-1])
      return {1'b1, {(PSUM_W-1){1'b0}}};
    else
      return {1'b0, {(PSUM_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/psum_fifo.sv
// Synchronous FIFO, head visible one cycle after push, no bypass.
// Push while full and pop while empty are dropped.
module psum_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_dat,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         w_push;
  logic         w_pop;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dat   = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr[AW-1:0]] <= i_dat;
        r_wr <= r_wr + (AW+1)'(1);
      end
      if (w_pop) r_rd <= r_rd + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/psum_tx.sv
// PE-side partial-sum transmitter: saturate, tag, buffer and send; report layer done.
// Accept-to-pkt_valid latency 1 cycle; psum_ready drops while the buffer is full.
module psum_tx
  import psum_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  input  logic [IDX_W-1:0]  cfg_tot_num,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic              psum_valid,
  input  logic [ACC_W-1:0]  psum_data,
  output logic              psum_ready,
  output logic              pkt_valid,
  output logic [PKT_W-1:0]  pkt_data,
  input  logic              pkt_ready,
  output logic              done_valid,
  input  logic              done_ack
);

  state_e            r_state;
  state_e            w_next;
  logic [IDX_W-1:0]  r_tot;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_sent;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_cfg_take;
  pkt_t              w_push_pkt;

  assign w_cfg_take = cfg_valid && (cfg_tot_num != '0);
  assign w_push     = psum_valid && psum_ready;
  assign pkt_valid  = !w_empty;
  assign w_pop      = pkt_valid && pkt_ready;
  assign w_push_pkt = pack_psum(r_idx, r_src, r_dst, sat_psum(psum_data));

  psum_fifo #(.W($bits(pkt_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_dat   (w_push_pkt),
    .i_pop   (w_pop),
    .o_dat   (pkt_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_next     = r_state;
    psum_ready = 1'b0;
    done_valid = 1'b0;
    case (r_state)
      IDLE:  if (w_cfg_take) w_next = RUN;
      RUN: begin
        psum_ready = !w_full && (r_idx < r_tot);
        if (r_idx == r_tot) w_next = DRAIN;
      end
      DRAIN: if ((r_sent == r_tot) && w_empty) w_next = DONE;
      DONE: begin
        done_valid = 1'b1;
        if (done_ack) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_tot   <= '0;
      r_idx   <= '0;
      r_sent  <= '0;
      r_src   <= '0;
      r_dst   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && w_cfg_take) begin
        r_tot  <= cfg_tot_num;
        r_src  <= cfg_src;
        r_dst  <= cfg_dst;
        r_idx  <= '0;
        r_sent <= '0;
      end else begin
        if (w_push) r_idx  <= r_idx + IDX_W'(1);
        if (w_pop)  r_sent <= r_sent + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_psum_tx.sv
// Bench for psum_tx: table of saturation vectors plus hand-written layer
// sequences; packets are checked against a queue filled as psums are accepted.
module tb_psum_tx;
  import psum_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic [IDX_W-1:0]  cfg_tot_num;
  logic [ADDR_W-1:0] cfg_src;
  logic [ADDR_W-1:0] cfg_dst;
  logic              psum_valid;
  logic [ACC_W-1:0]  psum_data;
  logic              psum_ready;
  logic              pkt_valid;
  logic [PKT_W-1:0]  pkt_data;
  logic              pkt_ready;
  logic              done_valid;
  logic              done_ack;

  always #5 clk = ~clk;

  psum_tx dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_tot_num (cfg_tot_num),
    .cfg_src     (cfg_src),
    .cfg_dst     (cfg_dst),
    .psum_valid  (psum_valid),
    .psum_data   (psum_data),
    .psum_ready  (psum_ready),
    .pkt_valid   (pkt_valid),
    .pkt_data    (pkt_data),
    .pkt_ready   (pkt_ready),
    .done_valid  (done_valid),
    .done_ack    (done_ack)
  );

  typedef struct {
    int                acc;
    logic [PSUM_W-1:0] exp;
  } vec_t;
  vec_t vecs[10];

  int n_chk  = 0;
  int n_pass = 0;
  int n_acc  = 0;
  bit bp_done;

  logic [PKT_W-1:0]  sb_q[$];
  logic [IDX_W-1:0]  m_idx;
  logic [ADDR_W-1:0] m_src;
  logic [ADDR_W-1:0] m_dst;
  logic [PSUM_W-1:0] m_exp;
  logic [PKT_W-1:0]  hold_dat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Packets are checked at negedge; the handshake seen here fires on the next posedge.
  always @(negedge clk) begin
    if (!rst && pkt_valid && pkt_ready) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_pkt: got 0x%0h, expected no packet", pkt_data);
      end else begin
        chk("pkt", 32'(pkt_data), 32'(sb_q.pop_front()));
      end
    end
    if (!rst && psum_valid && psum_ready) begin
      sb_q.push_back({m_idx, m_src, m_dst, m_exp});
      m_idx++;
      n_acc++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_cfg(input int tot, input int src, input int dst, input bit take);
    cfg_valid   = 1'b1;
    cfg_tot_num = IDX_W'(tot);
    cfg_src     = ADDR_W'(src);
    cfg_dst     = ADDR_W'(dst);
    tick();
    cfg_valid = 1'b0;
    if (take) begin
      m_idx = '0;
      m_src = ADDR_W'(src);
      m_dst = ADDR_W'(dst);
    end
  endtask

  task automatic send(input int acc, input logic [PSUM_W-1:0] exp);
    bit ok;
    ok         = 1'b0;
    psum_valid = 1'b1;
    psum_data  = ACC_W'(acc);
    m_exp      = exp;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (psum_ready) ok = 1'b1;
      tick();
    end
    psum_valid = 1'b0;
    if (!ok) begin
      n_chk++;
      $display("FAIL send_timeout: psum %0d got no psum_ready, expected accept", acc);
    end
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (done_valid) ok = 1'b1;
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic finish_layer();
    tick();
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
  endtask

  initial begin
    vecs[0] = '{10,     13'h000A};
    vecs[1] = '{-5,     13'h1FFB};
    vecs[2] = '{100,    13'h0064};
    vecs[3] = '{5000,   13'h0FFF};
    vecs[4] = '{-70000, 13'h1000};
    vecs[5] = '{4095,   13'h0FFF};
    vecs[6] = '{-4096,  13'h1000};
    vecs[7] = '{4096,   13'h0FFF};
    vecs[8] = '{-4097,  13'h1000};
    vecs[9] = '{0,      13'h0000};

    rst = 1'b1; cfg_valid = 1'b0; cfg_tot_num = '0; cfg_src = '0; cfg_dst = '0;
    psum_valid = 1'b0; psum_data = '0; pkt_ready = 1'b0; done_ack = 1'b0;
    m_idx = '0; m_src = '0; m_dst = '0; m_exp = '0;
    tick(2);
    @(negedge clk);
    chk("rst_pkt_valid",  32'(pkt_valid),  32'd0);
    chk("rst_psum_ready", 32'(psum_ready), 32'd0);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_pkt_data",   32'(pkt_data),   32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Basic layer, done/ack handshake, cfg ignored while DONE
    pkt_ready = 1'b1;
    do_cfg(3, 2, 9, 1'b1);
    send(10, 13'h000A);
    chk("latency_1", 32'(pkt_valid), 32'd1);
    send(-5, 13'h1FFB);
    send(100, 13'h0064);
    wait_done("done_basic");
    chk("sb_empty_basic", 32'(sb_q.size()), 32'd0);
    tick(3);
    @(negedge clk);
    chk("done_hold", 32'(done_valid), 32'd1);
    tick();
    do_cfg(5, 1, 1, 1'b0);
    @(negedge clk);
    chk("done_cfg_ignored", 32'(done_valid), 32'd1);
    tick();
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    @(negedge clk);
    chk("ack_done_low", 32'(done_valid), 32'd0);
    chk("idle_not_ready", 32'(psum_ready), 32'd0);
    tick();

    // Saturation table
    do_cfg(10, 5, 12, 1'b1);
    for (int i = 0; i < 10; i++) send(vecs[i].acc, vecs[i].exp);
    wait_done("done_table");
    chk("sb_empty_table", 32'(sb_q.size()), 32'd0);
    finish_layer();

    // Backpressure: four fit, the rest wait for the router
    pkt_ready = 1'b0;
    do_cfg(6, 3, 4, 1'b1);
    n_acc   = 0;
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          int v;
          logic [31:0] t;
          v = i * 100 - 200;
          t = v;
          send(v, t[PSUM_W-1:0]);
        end
        bp_done = 1'b1;
      end
    join_none
    tick(12);
    @(negedge clk);
    chk("bp_accepted_4",   32'(n_acc),      32'd4);
    chk("bp_not_ready",    32'(psum_ready), 32'd0);
    chk("bp_pkt_valid",    32'(pkt_valid),  32'd1);
    chk("bp_head",         32'(pkt_data),   {4'h0, 7'd0, 4'd3, 4'd4, 13'h1F38});
    hold_dat = pkt_data;
    tick(3);
    @(negedge clk);
    chk("bp_stable", 32'(pkt_data), 32'(hold_dat));
    tick();
    pkt_ready = 1'b1;
    for (int c = 0; c < 200 && !bp_done; c++) tick();
    chk("bp_all_sent", 32'(bp_done), 32'd1);
    wait_done("done_bp");
    chk("bp_accepted_6", 32'(n_acc), 32'd6);
    chk("sb_empty_bp", 32'(sb_q.size()), 32'd0);
    finish_layer();

    // Ordering: no accept beyond tot_num, cfg during RUN ignored
    n_acc = 0;
    do_cfg(2, 6, 1, 1'b1);
    send(7, 13'h0007);
    do_cfg(9, 15, 15, 1'b0);
    send(8, 13'h0008);
    begin
      bit quiet;
      quiet      = 1'b1;
      psum_valid = 1'b1;
      psum_data  = ACC_W'(9);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (psum_ready) quiet = 1'b0;
        tick();
      end
      psum_valid = 1'b0;
      chk("ord_no_extra_ready", 32'(quiet), 32'd1);
    end
    wait_done("done_order");
    chk("ord_accepted_2", 32'(n_acc), 32'd2);
    chk("sb_empty_order", 32'(sb_q.size()), 32'd0);
    finish_layer();

    // Reset mid-layer discards buffered packets
    pkt_ready = 1'b0;
    do_cfg(5, 2, 3, 1'b1);
    send(1, 13'h0001);
    send(2, 13'h0002);
    @(negedge clk);
    chk("mid_pkt_valid", 32'(pkt_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_pkt_valid",  32'(pkt_valid),  32'd0);
    chk("mid_rst_psum_ready", 32'(psum_ready), 32'd0);
    sb_q.delete();
    tick(2);
    rst = 1'b0;
    tick();
    pkt_ready = 1'b1;
    n_acc = 0;
    do_cfg(1, 4, 8, 1'b1);
    send(-1, 13'h1FFF);
    wait_done("done_after_rst");
    chk("post_rst_accepted_1", 32'(n_acc), 32'd1);
    chk("sb_empty_rst", 32'(sb_q.size()), 32'd0);
    finish_layer();

    // done_ack held high throughout: only acts once DONE is reached
    done_ack = 1'b1;
    do_cfg(2, 1, 2, 1'b1);
    send(50, 13'h0032);
    send(-50, 13'h1FCE);
    wait_done("done_ack_held");
    tick();
    done_ack = 1'b0;
    @(negedge clk);
    chk("ack_held_idle", 32'(done_valid), 32'd0);
    chk("sb_empty_ack", 32'(sb_q.size()), 32'd0);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
